// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one sequential multiplier between NREQ requesters. A round-robin
//   arbiter picks a winner in IDLE, latches its operands onto mul_md/mul_mr,
//   pulses mul_start, waits for mul_done and returns the product to the owner
//   with a one-cycle rsp_valid. A watchdog aborts a multiply that never
//   finishes and answers with rsp_err=1 and a zero product.
//
// Ports
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset (shared with the multiplier)
//   req        per-requester request, held with operands until ack
//   md_in      packed multiplicands, requester i at [i*WIDTH +: WIDTH]
//   mr_in      packed multipliers, same packing
//   ack        one-hot 1-cycle pulse: operands of that requester accepted
//   rsp_valid  one-hot 1-cycle pulse: response for that requester
//   rsp_prod   product, valid with rsp_valid, held until the next response
//   rsp_err    qualifies rsp_valid: 1 = watchdog abort
//   busy       high in every state except IDLE
//   mul_start  1-cycle start pulse to the multiplier control
//   mul_md     multiplicand to the datapath, stable from ISSUE to end of WAIT
//   mul_mr     multiplier to the datapath/control, stable likewise
//   mul_done   done from the multiplier control
//   mul_prod   running-sum output of the multiplier datapath

module mult_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 4 * WIDTH + 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     md_in,
    input  logic [NREQ*WIDTH-1:0]     mr_in,
    output logic [NREQ-1:0]           ack,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [2*WIDTH-1:0]        rsp_prod,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      mul_start,
    output logic [WIDTH-1:0]          mul_md,
    output logic [WIDTH-1:0]          mul_mr,
    input  logic                      mul_done,
    input  logic [2*WIDTH-1:0]        mul_prod
);

    localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    owner_q, owner_d;

    logic [NREQ-1:0]     ack_d;
    logic [NREQ-1:0]     rsp_valid_d;
    logic [PROD_W-1:0]   rsp_prod_d;
    logic                rsp_err_d;
    logic                busy_d;
    logic                mul_start_d;
    logic [WIDTH-1:0]    mul_md_d;
    logic [WIDTH-1:0]    mul_mr_d;

    // Unpacked views of the operand buses so the winner can be indexed directly
    logic [WIDTH-1:0]    md_arr [NREQ];
    logic [WIDTH-1:0]    mr_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign md_arr[gi] = md_in[gi*WIDTH +: WIDTH];
        assign mr_arr[gi] = mr_in[gi*WIDTH +: WIDTH];
    end

    // Round-robin scan: first set request starting at rr_ptr, wrapping mod NREQ
    logic                grant_vld;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    grant_next;
    logic [PTR_W-1:0]    scan_ptr;
    int unsigned         scan;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = 0;
        scan_ptr  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = 32'(rr_ptr_q) + k;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            scan_ptr = PTR_W'(scan);
            if (!grant_vld && req[scan_ptr]) begin
                grant_vld = 1'b1;
                grant_idx = scan_ptr;
            end
        end
    end

    // Pointer moves just past the winner; explicit wrap handles non-power-of-2 NREQ
    assign grant_next = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        ack_d       = '0;
        rsp_valid_d = '0;
        rsp_prod_d  = rsp_prod;
        rsp_err_d   = 1'b0;
        mul_start_d = 1'b0;
        mul_md_d    = mul_md;
        mul_mr_d    = mul_mr;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    owner_d     = grant_idx;
                    mul_md_d    = md_arr[grant_idx];
                    mul_mr_d    = mr_arr[grant_idx];
                    ack_d       = NREQ'(1) << grant_idx;
                    // start is registered so it is high during ISSUE only
                    mul_start_d = 1'b1;
                    rr_ptr_d    = grant_next;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // saturate so the counter can never wrap
                if (cnt_q != CNT_W'(TIMEOUT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // done wins over a timeout landing in the same cycle
                if (mul_done) begin
                    state_d = S_CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_prod_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = NREQ'(1) << owner_q;
                    state_d     = S_IDLE;
                end
            end

            S_CAPTURE: begin
                // one cycle after done, so the last shift/add has landed
                rsp_prod_d  = mul_prod;
                rsp_err_d   = 1'b0;
                rsp_valid_d = NREQ'(1) << owner_q;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            owner_q   <= '0;
            ack       <= '0;
            rsp_valid <= '0;
            rsp_prod  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_md    <= '0;
            mul_mr    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            ack       <= ack_d;
            rsp_valid <= rsp_valid_d;
            rsp_prod  <= rsp_prod_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
            mul_start <= mul_start_d;
            mul_md    <= mul_md_d;
            mul_mr    <= mul_mr_d;
        end
    end

    // Handshake pulses are never multi-hot
    a_ack_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
    a_rsp_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter with a behavioural shift-add multiplier attached.
module tb_mult_share_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned TO = 4 * W + 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*W-1:0]    md_in;
    logic [N*W-1:0]    mr_in;
    logic [N-1:0]      ack;
    logic [N-1:0]      rsp_valid;
    logic [PW-1:0]     rsp_prod;
    logic              rsp_err;
    logic              busy;
    logic              mul_start;
    logic [W-1:0]      mul_md;
    logic [W-1:0]      mul_mr;
    logic              mul_done;
    logic [PW-1:0]     mul_prod;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NREQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .md_in     (md_in),
        .mr_in     (mr_in),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_prod  (rsp_prod),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_md    (mul_md),
        .mul_mr    (mul_mr),
        .mul_done  (mul_done),
        .mul_prod  (mul_prod)
    );

    // Sequential shift-add multiplier: one bit per cycle, done on the last bit
    logic          stub;
    logic          m_run;
    logic [1:0]    m_cnt;
    logic [PW-1:0] m_acc;

    always @(posedge clk) begin
        if (rst) begin
            m_run <= 1'b0;
            m_cnt <= '0;
            m_acc <= '0;
        end else if (mul_start) begin
            m_run <= 1'b1;
            m_cnt <= '0;
            m_acc <= '0;
        end else if (m_run) begin
            if (mul_mr[m_cnt]) m_acc <= m_acc + (PW'(mul_md) << m_cnt);
            m_cnt <= m_cnt + 2'd1;
            if (m_cnt == 2'd3) m_run <= 1'b0;
        end
    end

    assign mul_done = m_run && (m_cnt == 2'd3) && !stub;
    assign mul_prod = m_acc;

    typedef struct {
        int            idx;
        logic [PW-1:0] prod;
        logic          err;
    } rsp_t;

    rsp_t sb[$];
    int   exp_ack[$];

    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int last_ack_cyc = -100;
    int last_rsp_cyc = -100;
    int b2b_hits = 0;
    int start_cnt = 0;

    logic [N-1:0] rearm;
    logic [W-1:0] rearm_md [N];
    logic [W-1:0] rearm_mr [N];

    task automatic set_req(input int i, input logic [W-1:0] md, input logic [W-1:0] mr);
        md_in[i*W +: W] = md;
        mr_in[i*W +: W] = mr;
        req[i] = 1'b1;
    endtask

    task automatic push(input int i, input logic [W-1:0] md, input logic [W-1:0] mr,
                        input logic err);
        rsp_t e;
        e.idx  = i;
        e.prod = err ? PW'(0) : PW'(md) * PW'(mr);
        e.err  = err;
        sb.push_back(e);
        exp_ack.push_back(i);
    endtask

    // One clock: sample #1 after the edge, act as requesters, consume scoreboard
    task automatic tick();
        int   g;
        int   ea;
        rsp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (mul_start) start_cnt++;

        total++;
        if (mul_start !== (ack != '0)) begin
            $display("FAIL start_with_ack: mul_start=%0b ack=%b at cyc %0d", mul_start, ack, cyc);
        end else begin
            passed++;
        end

        if (ack != '0) begin
            g = 0;
            for (int i = 0; i < N; i++) if (ack[i]) g = i;
            total++;
            if ($countones(ack) != 1 || exp_ack.size() == 0) begin
                $display("FAIL ack_grant: ack=%b unexpected (pending %0d)", ack, exp_ack.size());
            end else begin
                ea = exp_ack.pop_front();
                if (g !== ea) $display("FAIL ack_grant: got %0d expected %0d", g, ea);
                else passed++;
            end
            if (last_rsp_cyc == cyc - 1) b2b_hits++;
            last_ack_cyc = cyc;
            if (rearm[g]) begin
                md_in[g*W +: W] = rearm_md[g];
                mr_in[g*W +: W] = rearm_mr[g];
                rearm[g] = 1'b0;
            end else begin
                req[g] = 1'b0;
            end
        end

        if (rsp_valid != '0) begin
            g = 0;
            for (int i = 0; i < N; i++) if (rsp_valid[i]) g = i;
            last_rsp_cyc = cyc;
            total++;
            if ($countones(rsp_valid) != 1 || sb.size() == 0) begin
                $display("FAIL rsp_unexpected: rsp_valid=%b pending %0d", rsp_valid, sb.size());
            end else begin
                passed++;
                e = sb.pop_front();
                total++;
                if (g !== e.idx) $display("FAIL rsp_idx: got %0d expected %0d", g, e.idx);
                else passed++;
                total++;
                if (rsp_prod !== e.prod) $display("FAIL rsp_prod: got %0d expected %0d", rsp_prod, e.prod);
                else passed++;
                total++;
                if (rsp_err !== e.err) $display("FAIL rsp_err: got %0b expected %0b", rsp_err, e.err);
                else passed++;
            end
        end
    endtask

    task automatic run(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || exp_ack.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (sb.size() != 0 || exp_ack.size() != 0) begin
            $display("FAIL %s_timeout: %0d responses and %0d acks still pending", name,
                     sb.size(), exp_ack.size());
            sb.delete();
            exp_ack.delete();
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++; if (ack !== '0)        $display("FAIL reset_ack: got %b expected 0", ack); else passed++;
        total++; if (rsp_valid !== '0)  $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passed++;
        total++; if (rsp_prod !== '0)   $display("FAIL reset_rsp_prod: got %0d expected 0", rsp_prod); else passed++;
        total++; if (rsp_err !== 1'b0)  $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); else passed++;
        total++; if (busy !== 1'b0)     $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (mul_start !== 1'b0) $display("FAIL reset_mul_start: got %b expected 0", mul_start); else passed++;
        total++; if (mul_md !== '0)     $display("FAIL reset_mul_md: got %0d expected 0", mul_md); else passed++;
        total++; if (mul_mr !== '0)     $display("FAIL reset_mul_mr: got %0d expected 0", mul_mr); else passed++;
        rst = 1'b0;
        tick();
        total++; if (busy !== 1'b0)     $display("FAIL idle_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_round_robin();
        int b0;
        b0 = b2b_hits;
        set_req(0, 4'd3, 4'd5);
        set_req(1, 4'd7, 4'd2);
        set_req(2, 4'd11, 4'd13);
        set_req(3, 4'd15, 4'd1);
        rearm[0] = 1'b1;
        rearm_md[0] = 4'd6;
        rearm_mr[0] = 4'd9;
        push(0, 4'd3, 4'd5, 1'b0);
        push(1, 4'd7, 4'd2, 1'b0);
        push(2, 4'd11, 4'd13, 1'b0);
        push(3, 4'd15, 4'd1, 1'b0);
        push(0, 4'd6, 4'd9, 1'b0);
        run(200, "round_robin");
        total++;
        if (b2b_hits - b0 != 4) $display("FAIL back_to_back: got %0d gapless grants expected 4", b2b_hits - b0);
        else passed++;
    endtask

    task automatic test_single();
        int s0;
        s0 = start_cnt;
        set_req(0, 4'd3, 4'd5);
        push(0, 4'd3, 4'd5, 1'b0);
        run(50, "single");
        total++;
        if (start_cnt - s0 != 1) $display("FAIL single_starts: got %0d expected 1", start_cnt - s0);
        else passed++;
        total++;
        if (last_rsp_cyc - last_ack_cyc != 6)
            $display("FAIL single_latency: got %0d expected 6", last_rsp_cyc - last_ack_cyc);
        else passed++;
    endtask

    task automatic test_corners();
        set_req(1, 4'd15, 4'd15);
        push(1, 4'd15, 4'd15, 1'b0);
        run(50, "max_operands");
        set_req(2, 4'd9, 4'd0);
        push(2, 4'd9, 4'd0, 1'b0);
        run(50, "zero_multiplier");
    endtask

    task automatic test_wrap();
        set_req(1, 4'd4, 4'd4);
        push(1, 4'd4, 4'd4, 1'b0);
        run(50, "wrap_setup");
        set_req(0, 4'd2, 4'd3);
        set_req(1, 4'd5, 4'd5);
        push(0, 4'd2, 4'd3, 1'b0);
        push(1, 4'd5, 4'd5, 1'b0);
        run(100, "wrap");
    endtask

    task automatic test_timeout();
        stub = 1'b1;
        set_req(3, 4'd7, 4'd7);
        push(3, 4'd7, 4'd7, 1'b1);
        run(80, "timeout");
        total++;
        if (last_rsp_cyc - last_ack_cyc != TO + 1)
            $display("FAIL timeout_latency: got %0d expected %0d", last_rsp_cyc - last_ack_cyc, TO + 1);
        else passed++;
        stub = 1'b0;
        set_req(0, 4'd5, 4'd6);
        push(0, 4'd5, 4'd6, 1'b0);
        run(50, "after_timeout");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        set_req(1, 4'd10, 4'd12);
        exp_ack.push_back(1);
        while (exp_ack.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (exp_ack.size() != 0) begin
            $display("FAIL midrst_ack: no grant seen for requester 1");
            exp_ack.delete();
        end else begin
            passed++;
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        total++; if (ack !== '0)        $display("FAIL midrst_ack_clear: got %b expected 0", ack); else passed++;
        total++; if (rsp_valid !== '0)  $display("FAIL midrst_rsp_valid: got %b expected 0", rsp_valid); else passed++;
        total++; if (rsp_prod !== '0)   $display("FAIL midrst_rsp_prod: got %0d expected 0", rsp_prod); else passed++;
        total++; if (rsp_err !== 1'b0)  $display("FAIL midrst_rsp_err: got %b expected 0", rsp_err); else passed++;
        total++; if (busy !== 1'b0)     $display("FAIL midrst_busy: got %b expected 0", busy); else passed++;
        total++; if (mul_start !== 1'b0) $display("FAIL midrst_mul_start: got %b expected 0", mul_start); else passed++;
        total++; if (mul_md !== '0)     $display("FAIL midrst_mul_md: got %0d expected 0", mul_md); else passed++;
        total++; if (mul_mr !== '0)     $display("FAIL midrst_mul_mr: got %0d expected 0", mul_mr); else passed++;
        rst = 1'b0;
        // dropped job must never answer; any rsp_valid here hits an empty scoreboard
        repeat (10) tick();
        set_req(1, 4'd3, 4'd3);
        set_req(3, 4'd2, 4'd2);
        push(1, 4'd3, 4'd3, 1'b0);
        push(3, 4'd2, 4'd2, 1'b0);
        run(100, "after_reset");
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        md_in = '0;
        mr_in = '0;
        stub  = 1'b0;
        rearm = '0;
        for (int i = 0; i < N; i++) begin
            rearm_md[i] = '0;
            rearm_mr[i] = '0;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_corners();
        test_wrap();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
